// File: rtl/obi_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// obi_mem_arbiter_pkg
//   Shared constants and types for the two-host OBI memory arbiter.
//   - HOST_DMEM / HOST_IMEM : 1-bit host IDs stored in the outstanding tracker
//   - OBI_MAX_OUTSTANDING   : default depth of the outstanding-transaction tracker
//   - arb_state_e           : arbiter address-phase state (UNLOCKED / LOCKED)
// -----------------------------------------------------------------------------
package obi_mem_arbiter_pkg;

  localparam logic HOST_DMEM = 1'b0;
  localparam logic HOST_IMEM = 1'b1;

  localparam int unsigned OBI_MAX_OUTSTANDING = 2;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/obi_mem_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// obi_id_fifo
//   Synchronous FIFO of 1-bit host IDs. One entry per granted-but-unanswered
//   OBI transaction; the head entry names the host that owns the next response.
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset (empties the FIFO)
//   i_push     write i_push_id (ignored when full)
//   i_push_id  host ID to record
//   i_pop      drop the head entry (ignored when empty)
//   o_head_id  host ID at the head
//   o_full     count == DEPTH
//   o_empty    count == 0
//   o_count    number of stored IDs
// -----------------------------------------------------------------------------
module obi_id_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic             i_push_id,
  input  logic             i_pop,
  output logic             o_head_id,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [DEPTH-1:0] r_ids;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Pointers wrap at DEPTH-1 so any non-power-of-two depth works.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_id = r_ids[r_rptr];

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: only pointers and count are reset; stale ID storage is unreachable
  // once the FIFO is empty, so the storage array needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_ids[r_wptr] <= i_push_id;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= next_ptr(r_wptr);
      if (w_do_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// obi_mem_arbiter
//   Shares one OBI device port between host 0 (dmem) and host 1 (imem).
//   Round-robin on ties, address phase locked to the chosen host until the
//   device grants, responses routed back in order via an ID FIFO.
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   hN_req_i / hN_gnt_o        host N address-phase handshake
//   hN_addr_i/we_i/be_i/wdata_i host N request fields
//   hN_rvalid_o / hN_rdata_o   host N response (rdata is a pass-through)
//   dev_req_o / dev_gnt_i      device address-phase handshake
//   dev_addr_o/we_o/be_o/wdata_o fields of the selected host (combinational)
//   dev_rvalid_i / dev_rdata_i device response
//   protocol_err_o             sticky flag: stray response or abandoned request
// -----------------------------------------------------------------------------
module obi_mem_arbiter
  import obi_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = OBI_MAX_OUTSTANDING
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                h0_req_i,
  output logic                h0_gnt_o,
  input  logic [ADDR_W-1:0]   h0_addr_i,
  input  logic                h0_we_i,
  input  logic [DATA_W/8-1:0] h0_be_i,
  input  logic [DATA_W-1:0]   h0_wdata_i,
  output logic                h0_rvalid_o,
  output logic [DATA_W-1:0]   h0_rdata_o,

  input  logic                h1_req_i,
  output logic                h1_gnt_o,
  input  logic [ADDR_W-1:0]   h1_addr_i,
  input  logic                h1_we_i,
  input  logic [DATA_W/8-1:0] h1_be_i,
  input  logic [DATA_W-1:0]   h1_wdata_i,
  output logic                h1_rvalid_o,
  output logic [DATA_W-1:0]   h1_rdata_o,

  output logic                dev_req_o,
  input  logic                dev_gnt_i,
  output logic [ADDR_W-1:0]   dev_addr_o,
  output logic                dev_we_o,
  output logic [DATA_W/8-1:0] dev_be_o,
  output logic [DATA_W-1:0]   dev_wdata_o,
  input  logic                dev_rvalid_i,
  input  logic [DATA_W-1:0]   dev_rdata_i,

  output logic                protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e r_state;
  logic       r_lock_host;
  logic       r_rr_last;
  logic       r_err;

  logic             w_sel;
  logic             w_dev_req;
  logic             w_can_issue;
  logic             w_handshake;
  logic             w_lock_req;
  logic             w_lock_drop;
  logic             w_pop;
  logic             w_stray_rsp;
  logic             w_head_id;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;

  // No bypass: a response popping this cycle does not free a slot until next.
  assign w_can_issue = (w_count < CNT_W'(MAX_OUTSTANDING));
  assign w_lock_req  = (r_lock_host == HOST_IMEM) ? h1_req_i : h0_req_i;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_sel     = HOST_DMEM;
    w_dev_req = 1'b0;
    if (r_state == ST_LOCKED) begin
      // A lock only starts on an ungranted issue, so the tracker cannot be
      // full here; the ~w_full term merely keeps that invariant self-evident.
      w_sel     = r_lock_host;
      w_dev_req = w_lock_req & ~w_full;
    end else if (w_can_issue) begin
      if (h0_req_i && h1_req_i) begin
        w_sel = ~r_rr_last;
      end else if (h1_req_i) begin
        w_sel = HOST_IMEM;
      end
      w_dev_req = h0_req_i | h1_req_i;
    end
  end

  assign w_handshake = w_dev_req & dev_gnt_i;
  assign w_lock_drop = (r_state == ST_LOCKED) & ~w_lock_req;
  assign w_pop       = dev_rvalid_i & ~w_empty;
  assign w_stray_rsp = dev_rvalid_i & w_empty;

  assign dev_req_o   = w_dev_req;
  assign dev_addr_o  = (w_sel == HOST_IMEM) ? h1_addr_i  : h0_addr_i;
  assign dev_we_o    = (w_sel == HOST_IMEM) ? h1_we_i    : h0_we_i;
  assign dev_be_o    = (w_sel == HOST_IMEM) ? h1_be_i    : h0_be_i;
  assign dev_wdata_o = (w_sel == HOST_IMEM) ? h1_wdata_i : h0_wdata_i;

  assign h0_gnt_o    = w_handshake & (w_sel == HOST_DMEM);
  assign h1_gnt_o    = w_handshake & (w_sel == HOST_IMEM);

  assign h0_rvalid_o = w_pop & (w_head_id == HOST_DMEM);
  assign h1_rvalid_o = w_pop & (w_head_id == HOST_IMEM);
  assign h0_rdata_o  = dev_rdata_i;
  assign h1_rdata_o  = dev_rdata_i;

  assign protocol_err_o = r_err;

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_push    (w_handshake),
    .i_push_id (w_sel),
    .i_pop     (w_pop),
    .o_head_id (w_head_id),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Address-phase FSM, round-robin pointer and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_UNLOCKED;
      r_lock_host <= HOST_DMEM;
      r_rr_last   <= HOST_IMEM;   // host 0 wins the first tie
      r_err       <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_state   <= ST_UNLOCKED;
        r_rr_last <= w_sel;
      end else if (w_dev_req) begin
        r_state     <= ST_LOCKED;
        r_lock_host <= w_sel;
      end else if (w_lock_drop) begin
        r_state <= ST_UNLOCKED;
      end
      if (w_lock_drop || w_stray_rsp) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obi_mem_arbiter
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a transaction-level model (ID queue, round-robin bit, lock owner).
// -----------------------------------------------------------------------------
module tb_obi_mem_arbiter;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        h_req   [2];
  logic [63:0] h_addr  [2];
  logic        h_we    [2];
  logic [7:0]  h_be    [2];
  logic [63:0] h_wdata [2];
  logic        h_gnt   [2];
  logic        h_rvalid[2];
  logic [63:0] h_rdata [2];

  logic        dev_req, dev_gnt, dev_we, dev_rvalid, perr;
  logic [63:0] dev_addr, dev_wdata, dev_rdata;
  logic [7:0]  dev_be;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  bit m_q[$];
  bit m_locked, m_lock_host, m_rr_last, m_err;

  // outputs sampled in the most recent cycle
  logic        o_gnt0, o_gnt1, o_rv0, o_rv1, o_dreq, o_err;
  logic [63:0] o_addr, o_rdata1;

  always #5 clk = ~clk;

  obi_mem_arbiter dut (
    .clk_i (clk), .rst_i (rst),
    .h0_req_i (h_req[0]), .h0_gnt_o (h_gnt[0]), .h0_addr_i (h_addr[0]),
    .h0_we_i (h_we[0]), .h0_be_i (h_be[0]), .h0_wdata_i (h_wdata[0]),
    .h0_rvalid_o (h_rvalid[0]), .h0_rdata_o (h_rdata[0]),
    .h1_req_i (h_req[1]), .h1_gnt_o (h_gnt[1]), .h1_addr_i (h_addr[1]),
    .h1_we_i (h_we[1]), .h1_be_i (h_be[1]), .h1_wdata_i (h_wdata[1]),
    .h1_rvalid_o (h_rvalid[1]), .h1_rdata_o (h_rdata[1]),
    .dev_req_o (dev_req), .dev_gnt_i (dev_gnt), .dev_addr_o (dev_addr),
    .dev_we_o (dev_we), .dev_be_o (dev_be), .dev_wdata_o (dev_wdata),
    .dev_rvalid_i (dev_rvalid), .dev_rdata_i (dev_rdata),
    .protocol_err_o (perr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      h_req[n] = 1'b0; h_addr[n] = '0; h_we[n] = 1'b0; h_be[n] = '0; h_wdata[n] = '0;
    end
    dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_rdata = '0;
  endtask

  // Entered just after a negedge; leaves just after the next negedge.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_locked = 1'b0; m_lock_host = 1'b0; m_rr_last = 1'b1; m_err = 1'b0;
  endtask

  // Compare one cycle against the model, then advance the model as the
  // coming clock edge will advance the DUT.
  task automatic cycle();
    bit sel, dreq, hs, pop_ok;
    #1;
    if (m_locked) begin
      sel  = m_lock_host;
      dreq = h_req[sel];
    end else begin
      sel  = (h_req[0] && h_req[1]) ? !m_rr_last : h_req[1];
      dreq = (h_req[0] || h_req[1]) && (m_q.size() < MAX);
    end
    hs     = dreq && dev_gnt;
    pop_ok = dev_rvalid && (m_q.size() > 0);

    o_gnt0 = h_gnt[0]; o_gnt1 = h_gnt[1]; o_rv0 = h_rvalid[0]; o_rv1 = h_rvalid[1];
    o_dreq = dev_req;  o_err  = perr;     o_addr = dev_addr;   o_rdata1 = h_rdata[1];

    check("dev_req", dev_req, dreq);
    check("h0_gnt", h_gnt[0], hs && !sel);
    check("h1_gnt", h_gnt[1], hs && sel);
    check("h0_rvalid", h_rvalid[0], pop_ok && (m_q[0] == 1'b0));
    check("h1_rvalid", h_rvalid[1], pop_ok && (m_q[0] == 1'b1));
    check("perr", perr, m_err);
    if (dreq) begin
      check("dev_addr", dev_addr, h_addr[sel]);
      check("dev_we", dev_we, h_we[sel]);
      check("dev_be", dev_be, h_be[sel]);
      check("dev_wdata", dev_wdata, h_wdata[sel]);
    end
    if (pop_ok) begin
      check("h0_rdata", h_rdata[0], dev_rdata);
      check("h1_rdata", h_rdata[1], dev_rdata);
    end

    if (pop_ok) void'(m_q.pop_front());
    else if (dev_rvalid) m_err = 1'b1;
    if (hs) begin
      m_q.push_back(sel); m_rr_last = sel; m_locked = 1'b0;
    end else if (dreq) begin
      m_locked = 1'b1; m_lock_host = sel;
    end else if (m_locked) begin
      m_locked = 1'b0; m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic set_host(input int n, input logic req, input logic [63:0] addr);
    h_req[n] = req; h_addr[n] = addr; h_we[n] = addr[3];
    h_be[n] = addr[11:4]; h_wdata[n] = ~addr;
  endtask

  task automatic drain();
    h_req[0] = 1'b0; h_req[1] = 1'b0; dev_gnt = 1'b0;
    while (m_q.size() > 0) begin
      dev_rvalid = 1'b1; dev_rdata = $urandom;
      cycle();
    end
    dev_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // reset state
    cycle();
    check("rst_dev_req", o_dreq, 1'b0);
    check("rst_perr", o_err, 1'b0);

    // 1: single host, response two cycles after grant
    set_host(1, 1'b1, 64'h8000_0000); dev_gnt = 1'b1;
    cycle();
    check("t1_h1_gnt", o_gnt1, 1'b1);
    check("t1_addr", o_addr, 64'h8000_0000);
    h_req[1] = 1'b0; dev_gnt = 1'b0;
    cycle();
    dev_rvalid = 1'b1; dev_rdata = 64'h13;
    cycle();
    check("t1_h1_rvalid", o_rv1, 1'b1);
    check("t1_h1_rdata", o_rdata1, 64'h13);
    check("t1_h0_rvalid", o_rv0, 1'b0);
    dev_rvalid = 1'b0;

    // 2: tie after reset alternates h0,h1,h0,h1
    do_reset();
    set_host(0, 1'b1, 64'h1000); set_host(1, 1'b1, 64'h2000); dev_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dev_rvalid = (i > 0);
      cycle();
      check("t2_h0_gnt", o_gnt0, (i % 2) == 0);
      check("t2_h1_gnt", o_gnt1, (i % 2) == 1);
      check("t2_addr", o_addr, ((i % 2) == 0) ? 64'h1000 : 64'h2000);
    end
    drain();

    // 3: locked on h1 while h0 joins
    do_reset();
    set_host(1, 1'b1, 64'hA100); dev_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) set_host(0, 1'b1, 64'hB000);
      dev_gnt = (i == 3);
      cycle();
      check("t3_addr", o_addr, 64'hA100);
      check("t3_h1_gnt", o_gnt1, i == 3);
      check("t3_h0_gnt", o_gnt0, 1'b0);
    end
    h_req[1] = 1'b0;
    cycle();
    check("t3_h0_gnt_next", o_gnt0, 1'b1);
    drain();

    // 4: tracker full, no same-cycle bypass
    do_reset();
    set_host(0, 1'b1, 64'h40); dev_gnt = 1'b1;
    cycle(); cycle();
    cycle();
    check("t4_full_req", o_dreq, 1'b0);
    dev_rvalid = 1'b1;
    cycle();
    check("t4_pop_nobypass", o_dreq, 1'b0);
    dev_rvalid = 1'b0;
    cycle();
    check("t4_resume", o_dreq, 1'b1);
    drain();

    // 5: ordering with a push+pop cycle
    do_reset();
    dev_gnt = 1'b1;
    set_host(0, 1'b1, 64'h50);
    cycle();
    h_req[0] = 1'b0; set_host(1, 1'b1, 64'h58); dev_rvalid = 1'b1;
    cycle();
    check("t5_rv_h0", o_rv0, 1'b1);
    check("t5_gnt_h1", o_gnt1, 1'b1);
    h_req[1] = 1'b0; set_host(0, 1'b1, 64'h60); dev_rvalid = 1'b0;
    cycle();
    h_req[0] = 1'b0; set_host(1, 1'b1, 64'h68);
    cycle();
    check("t5_count2_full", o_dreq, 1'b0);
    h_req[1] = 1'b0; dev_gnt = 1'b0; dev_rvalid = 1'b1;
    cycle();
    check("t5_rv_h1", o_rv1, 1'b1);
    cycle();
    check("t5_rv_h0_last", o_rv0, 1'b1);
    dev_rvalid = 1'b0;

    // 6: protocol errors are sticky until reset
    do_reset();
    set_host(0, 1'b1, 64'h70); dev_gnt = 1'b0;
    cycle();
    h_req[0] = 1'b0;
    cycle();
    check("t6_drop_req", o_dreq, 1'b0);
    cycle();
    check("t6_drop_err", o_err, 1'b1);
    do_reset();
    dev_rvalid = 1'b1;
    cycle();
    check("t6_stray_rv", o_rv0 | o_rv1, 1'b0);
    dev_rvalid = 1'b0;
    cycle(); cycle();
    check("t6_sticky", o_err, 1'b1);
    do_reset();
    cycle();
    check("t6_cleared", o_err, 1'b0);
    set_host(0, 1'b1, 64'h80); dev_gnt = 1'b1;
    cycle(); cycle();
    check("t6_count0_after_rst", o_gnt0, 1'b1);
    drain();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      for (int n = 0; n < 2; n++) begin
        if (!h_req[n] || h_gnt[n]) begin
          if ($urandom_range(99) < 55) set_host(n, 1'b1, {$urandom, $urandom});
          else h_req[n] = 1'b0;
        end else if ($urandom_range(999) < 5) begin
          h_req[n] = 1'b0;
        end
      end
      dev_gnt    = ($urandom_range(99) < 50);
      dev_rvalid = (m_q.size() > 0) ? ($urandom_range(99) < 45) : ($urandom_range(999) < 3);
      dev_rdata  = {$urandom, $urandom};
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
